fibo_stream_gen: RTL and testbench
==================================

FIBO_STREAM_GEN -- requirements
Module: fibo_stream_gen

Interface
REQ-001 Parameter W, default 8, sets the data width of each term in bits (W >= 2).
REQ-002 Parameter IW, default 8, sets the width of the term index in bits.
REQ-003 Parameter SEED0, default 0, is the first term after (re)seed.
REQ-004 Parameter SEED1, default 1, is the second term after (re)seed.
REQ-005 Parameter WRAP, default 0, selects overflow handling: 0 = stop, 1 = wrap modulo 2^W.
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  reseed and enter RUN; has priority over all other inputs except rst.
REQ-009 en  in  1  generation enable, sampled in RUN.
REQ-010 out_ready  in  1  downstream accepts out_data when high.
REQ-011 out_valid  out  1  out_data and out_index hold a valid term.
REQ-012 out_data  out  W  current term.
REQ-013 out_index  out  IW  index of the current term, starting at 0, wrapping modulo 2^IW.
REQ-014 overflow  out  1  sticky flag, set when any computed term carried out of W bits.
REQ-015 done  out  1  high in state DONE.

Function
REQ-016 The state machine has three states:
- IDLE: entered from reset; en is ignored.
- RUN: generating terms.
- DONE: entered only when WRAP=0.
REQ-017 Internal term registers a, b each carry a validity bit (av, bv); the next term is a + b computed at W+1 bits.
REQ-018 The output slot is free when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle.
REQ-019 In RUN, when en=1, the slot is free and av=1, the block performs a load-and-advance step:
- out_data<=a, out_index<=idx, out_valid<=1;
- a<=b, av<=bv;
- b<=(a+b)[W-1:0], bv<=av & bv & ~carry;
- idx<=idx+1.
REQ-020 In RUN, when the slot is free and en=0, out_valid goes to 0 on the next edge; no term is skipped or duplicated.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_index and out_valid remain stable regardless of en.
REQ-022 Latency: out_valid rises on the first edge after en=1 is sampled in RUN with a free slot, giving one term per cycle under continuous en and out_ready.
REQ-023 On carry out of a+b, overflow is set and stays set until rst or start.
REQ-024 If WRAP=1, the truncated sum is used and bv stays 1, so generation continues indefinitely.
REQ-025 If WRAP=0, when the slot is free and av=0, the FSM enters DONE with out_valid<=0; done=1 in DONE, and only start or rst leaves DONE.
REQ-026 start=1 in any state, including while out_valid=1 with out_ready=0, takes effect on the next edge:
- a=SEED0, b=SEED1, av=bv=1, idx=0;
- out_valid=0, overflow=0;
- state RUN.
REQ-027 If SEED0+SEED1 itself overflows, REQ-023 to REQ-025 apply unchanged.

Reset
REQ-028 rst=1 at a clock edge forces state IDLE, a=SEED0, b=SEED1, av=bv=1, idx=0, out_valid=0, out_data=0, out_index=0, overflow=0, done=0.
REQ-029 rst overrides start; asserting rst mid-stream discards any pending term.

Structure
REQ-030 A shared package fibo_pkg holds the state enum (IDLE, RUN, DONE) and the default parameter constants.
REQ-031 One sub-module, fibo_step, performs the combinational W+1-bit add, producing the sum and the carry.

Verification
REQ-032 The bench covers the following directed scenarios (default parameters unless stated):
- Reset, start, en=1, out_ready=1 -> terms 0,1,1,2,3,5,8,13,21,34,55,89,144,233 at index 0..13, one per cycle; done=1 and overflow=1 one cycle after 233; out_valid=0 thereafter.
- WRAP=1, same stimulus -> term 14 = 121 (377 mod 256), overflow=1 sticky, term 15 = 98 (233+121 mod 256), stream continues.
- out_ready held low for 5 cycles while out_data=5 -> out_data=5 and out_index=5 stable throughout; next accepted term is 8 at index 6.
- en deasserted for 3 cycles mid-stream -> out_valid=0 during the gap; sequence resumes without gap or duplicate.
- start pulsed in DONE and again while stalled at term 21 -> next valid term is 0 at index 0 with overflow=0.
- rst asserted concurrently with start in RUN -> state IDLE, out_valid=0; en alone produces no output until start.

Source files
------------

// File: rtl/fibo_pkg.sv
// Shared definitions for the Fibonacci stream generator: FSM state type and
// default parameter values.
package fibo_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } fibo_state_e;

  localparam int unsigned FiboW     = 8;
  localparam int unsigned FiboIW    = 8;
  localparam int unsigned FiboSeed0 = 0;
  localparam int unsigned FiboSeed1 = 1;
  localparam bit          FiboWrap  = 1'b0;

endpackage

// File: rtl/fibo_step.sv
// Combinational W+1-bit adder producing the next Fibonacci term and its carry.
module fibo_step #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b};
  assign sum      = full_sum[W-1:0];
  assign carry    = full_sum[W];

endmodule

// File: rtl/fibo_stream_gen.sv
// Fibonacci term stream with valid/ready output, sticky overflow and optional
// modulo-2^W wrap. a/b hold the next two terms, each tagged with a validity bit.
module fibo_stream_gen
  import fibo_pkg::*;
#(
  parameter int unsigned W     = FiboW,
  parameter int unsigned IW    = FiboIW,
  parameter logic [W-1:0] SEED0 = W'(FiboSeed0),
  parameter logic [W-1:0] SEED1 = W'(FiboSeed1),
  parameter bit          WRAP  = FiboWrap
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          en,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [IW-1:0] out_index,
  output logic          overflow,
  output logic          done
);

  fibo_state_e   state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic          av_q, av_d, bv_q, bv_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;
  logic [W-1:0]  data_q, data_d;
  logic [IW-1:0] index_q, index_d;
  logic          ovf_q, ovf_d;

  logic [W-1:0]  sum;
  logic          carry;
  logic          slot_free;

  fibo_step #(
    .W(W)
  ) u_step (
    .a    (a_q),
    .b    (b_q),
    .sum  (sum),
    .carry(carry)
  );

  assign slot_free = !valid_q || out_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    av_d    = av_q;
    bv_d    = bv_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    index_d = index_q;
    ovf_d   = ovf_q;

    if (start) begin
      state_d = StRun;
      a_d     = SEED0;
      b_d     = SEED1;
      av_d    = 1'b1;
      bv_d    = 1'b1;
      idx_d   = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end else if (state_q == StRun && slot_free) begin
      if (en && av_q) begin
        data_d  = a_q;
        index_d = idx_q;
        valid_d = 1'b1;
        a_d     = b_q;
        av_d    = bv_q;
        b_d     = sum;
        // In wrap mode the truncated sum is always a usable term.
        bv_d    = WRAP ? 1'b1 : (av_q & bv_q & ~carry);
        idx_d   = idx_q + IW'(1);
        if (carry) begin
          ovf_d = 1'b1;
        end
      end else if (!av_q && !WRAP) begin
        state_d = StDone;
        valid_d = 1'b0;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= SEED0;
      b_q     <= SEED1;
      av_q    <= 1'b1;
      bv_q    <= 1'b1;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      av_q    <= av_d;
      bv_q    <= bv_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      index_q <= index_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_index = index_q;
  assign overflow  = ovf_q;
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_fibo_stream_gen.sv
// Randomised and directed checks of fibo_stream_gen (stop and wrap variants)
// against a term-sequence model computed with plain arithmetic.
module tb_fibo_stream_gen;

  localparam int NT = 2048;

  logic clk = 1'b0;
  logic rst, start, en, rdy;

  logic [1:0]      vld, dn, ovf;
  logic [1:0][7:0] dat, idx;

  int checks = 0;
  int passes = 0;

  // Reference term sequence per instance (0: stop, 1: wrap)
  int unsigned t     [2][NT];
  bit          carry [2][NT];
  bit          ovf_at[2][NT];
  bit          ok_at [2][NT];

  // Handshake-level model state
  int unsigned ms[2];
  int unsigned mk[2];
  bit          mv[2];
  int unsigned md[2];
  int unsigned mi[2];
  bit          mo[2];
  bit          minit = 1'b0;

  bit          rec = 1'b0;
  int unsigned acc_d0[$], acc_i0[$], acc_d1[$], acc_i1[$];

  always #5 clk = ~clk;

  fibo_stream_gen u_dut0 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .en       (en),
    .out_ready(rdy),
    .out_valid(vld[0]),
    .out_data (dat[0]),
    .out_index(idx[0]),
    .overflow (ovf[0]),
    .done     (dn[0])
  );

  fibo_stream_gen #(
    .WRAP(1'b1)
  ) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .en       (en),
    .out_ready(rdy),
    .out_valid(vld[1]),
    .out_data (dat[1]),
    .out_index(idx[1]),
    .overflow (ovf[1]),
    .done     (dn[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int kclip(input int unsigned k);
    return (k < NT) ? int'(k) : NT - 1;
  endfunction

  // Model: terms come from the precomputed sequence; only acceptance timing is tracked
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ms[i] <= 0; mk[i] <= 0; mv[i] <= 1'b0; md[i] <= 0; mi[i] <= 0; mo[i] <= 1'b0;
      end else if (start) begin
        ms[i] <= 1; mk[i] <= 0; mv[i] <= 1'b0; mo[i] <= 1'b0;
      end else if (ms[i] == 1 && (!mv[i] || rdy)) begin
        if (!ok_at[i][kclip(mk[i])]) begin
          ms[i] <= 2;
          mv[i] <= 1'b0;
        end else if (en) begin
          mv[i] <= 1'b1;
          md[i] <= t[i][kclip(mk[i])];
          mi[i] <= mk[i] % 256;
          mo[i] <= mo[i] | ovf_at[i][kclip(mk[i])];
          mk[i] <= mk[i] + 1;
        end else begin
          mv[i] <= 1'b0;
        end
      end
    end
    if (rst) minit <= 1'b1;
  end

  always @(negedge clk) begin
    if (minit) begin
      for (int i = 0; i < 2; i++) begin
        chk(i == 0 ? "s_valid" : "w_valid", vld[i], mv[i]);
        chk(i == 0 ? "s_done" : "w_done", dn[i], (ms[i] == 2) ? 1 : 0);
        chk(i == 0 ? "s_overflow" : "w_overflow", ovf[i], mo[i]);
        chk(i == 0 ? "s_data" : "w_data", dat[i], md[i]);
        chk(i == 0 ? "s_index" : "w_index", idx[i], mi[i]);
      end
      if (rec && rdy) begin
        if (vld[0]) begin acc_d0.push_back(dat[0]); acc_i0.push_back(idx[0]); end
        if (vld[1]) begin acc_d1.push_back(dat[1]); acc_i1.push_back(idx[1]); end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_data0(input int unsigned v, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (vld[0] && dat[0] == v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int unsigned lit[14];
    bit ok;
    bit any_c;

    for (int i = 0; i < 2; i++) begin
      t[i][0] = 0; t[i][1] = 1; carry[i][0] = 0; carry[i][1] = 0;
      for (int n = 2; n < NT; n++) begin
        carry[i][n] = (t[i][n-2] + t[i][n-1]) >= 256;
        t[i][n]     = (t[i][n-2] + t[i][n-1]) % 256;
      end
      any_c = 1'b0;
      for (int k = 0; k < NT; k++) begin
        if (k >= 2 && carry[i][k]) any_c = 1'b1;
        ok_at[i][k]  = (i == 1) || !any_c;
        ovf_at[i][k] = (k + 2 < NT) ? carry[i][k+2] : 1'b0;
      end
    end
    chk("model_t13", t[0][13], 233);
    chk("model_t14", t[1][14], 121);
    chk("model_t15", t[1][15], 98);

    rst = 1'b1; start = 1'b0; en = 1'b0; rdy = 1'b0;
    step(3);
    rst = 1'b0; en = 1'b1; rdy = 1'b1;
    step(3);
    chk("idle_no_output", vld[0], 0);

    // Full default run and wrap run in parallel
    acc_d0.delete(); acc_i0.delete(); acc_d1.delete(); acc_i1.delete();
    rec = 1'b1;
    start = 1'b1; step(1); start = 1'b0;
    step(20);
    rec = 1'b0;
    lit = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
    chk("stop_count", acc_d0.size(), 14);
    for (int j = 0; j < 14 && j < acc_d0.size(); j++) begin
      chk("stop_term", acc_d0[j], lit[j]);
      chk("stop_idx", acc_i0[j], j);
    end
    chk("stop_done", dn[0], 1);
    chk("stop_ovf", ovf[0], 1);
    chk("wrap_count_ge16", acc_d1.size() >= 16, 1);
    if (acc_d1.size() >= 16) begin
      chk("wrap_t14", acc_d1[14], 121);
      chk("wrap_t15", acc_d1[15], 98);
      chk("wrap_i15", acc_i1[15], 15);
    end
    chk("wrap_ovf", ovf[1], 1);
    chk("wrap_not_done", dn[1], 0);

    // Stall on term 5
    start = 1'b1; step(1); start = 1'b0;
    wait_data0(5, ok);
    chk("found_5", ok, 1);
    rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_data", dat[0], 5);
      chk("stall_idx", idx[0], 5);
      chk("stall_valid", vld[0], 1);
    end
    rdy = 1'b1;
    @(negedge clk);
    chk("after_stall_data", dat[0], 8);
    chk("after_stall_idx", idx[0], 6);

    // Enable gap mid-stream
    step(1);
    acc_d0.delete(); acc_i0.delete(); acc_d1.delete(); acc_i1.delete();
    rec = 1'b1;
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(1);
      chk("gap_valid", vld[0], 0);
    end
    en = 1'b1;
    step(4);
    rec = 1'b0;
    chk("gap_enough", acc_d0.size() >= 4, 1);
    for (int j = 1; j < acc_d0.size(); j++) begin
      chk("gap_idx_seq", acc_i0[j], acc_i0[j-1] + 1);
      if (j >= 2) chk("gap_fib", acc_d0[j], (acc_d0[j-1] + acc_d0[j-2]) % 256);
    end

    // Start from DONE, then start while stalled on 21
    step(20);
    chk("pre_done", dn[0], 1);
    start = 1'b1; step(1); start = 1'b0;
    chk("restart_valid", vld[0], 0);
    chk("restart_done", dn[0], 0);
    chk("restart_ovf", ovf[0], 0);
    step(1);
    chk("restart_data", dat[0], 0);
    chk("restart_idx", idx[0], 0);
    chk("restart_v", vld[0], 1);
    wait_data0(21, ok);
    chk("found_21", ok, 1);
    rdy = 1'b0;
    step(3);
    start = 1'b1; step(1); start = 1'b0;
    chk("stall_start_valid", vld[0], 0);
    rdy = 1'b1;
    step(1);
    chk("stall_start_data", dat[0], 0);
    chk("stall_start_idx", idx[0], 0);
    chk("stall_start_ovf", ovf[0], 0);

    // rst together with start
    step(4);
    rst = 1'b1; start = 1'b1; step(1); rst = 1'b0; start = 1'b0;
    chk("rst_start_valid", vld[0], 0);
    chk("rst_start_data", dat[0], 0);
    step(5);
    chk("idle_en_only", vld[0], 0);
    start = 1'b1; step(1); start = 1'b0;
    step(3);
    chk("after_idle_start", vld[0], 1);

    // Long wrap run to exercise index wraparound
    start = 1'b1; step(1); start = 1'b0;
    step(300);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom % 100) == 0;
      start = ($urandom % 40) == 0;
      en    = ($urandom % 4) != 0;
      rdy   = ($urandom % 3) != 0;
      step(1);
    end
    rst = 1'b0; start = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
